// File: rtl/cregister_arb_pkg.sv
// ----------------------------------------------------------------------------
// cregister_arb_pkg
// Shared definitions for the cregister_arbiter block: FSM state encoding,
// default sizing constants and a constant-evaluable clog2 helper used to size
// index ports.
// ----------------------------------------------------------------------------
package cregister_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1
  } arb_state_e;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_CNTWIDTH  = 16;

  // Ceiling log2, never below 1 so that index vectors always have a bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// ----------------------------------------------------------------------------
// rr_arbiter_core
// Purely combinational round-robin pick. The eligible mask is rotated so that
// bit i_ptr lands at position 0, the lowest set bit is selected, and the
// resulting offset is rotated back into an absolute requester index.
//
// Ports:
//   i_elig   [NREQ-1:0]  eligible requesters
//   i_ptr    [IDXW-1:0]  index where the priority search starts
//   o_grant  [NREQ-1:0]  one-hot grant (all zero when nothing eligible)
//   o_idx    [IDXW-1:0]  index of the granted requester
//   o_valid              a grant was made
// ----------------------------------------------------------------------------
module rr_arbiter_core #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_valid
);

  localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NREQ);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDXW-1:0]   w_off;
  logic [IDXW:0]     w_sum;

  always_comb begin
    // Doubling the mask turns the rotate into a plain right shift.
    w_dbl   = {i_elig, i_elig} >> i_ptr;
    w_rot   = w_dbl[NREQ-1:0];
    w_off   = '0;
    o_valid = 1'b0;
    // Descending scan so the lowest set bit wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = IDXW'(i);
        o_valid = 1'b1;
      end
    end
    w_sum = {1'b0, w_off} + {1'b0, i_ptr};
    if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
    o_idx   = w_sum[IDXW-1:0];
    o_grant = o_valid ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/cregister_arbiter.sv
// ----------------------------------------------------------------------------
// cregister_arbiter
// Shared-write front end for a single data register. Up to NREQ producers
// request writes; a round-robin arbiter picks at most one per cycle, loads its
// data into the register and returns a one-cycle acknowledge. All outputs are
// registered, so there is no combinational path from req/req_data to outputs.
//
// Build option: define CREG_ARB_LOCK_EN to add the lock port and the LOCKED
// state, in which only the current owner may write and the round-robin pointer
// is frozen. Without the macro the FSM never leaves IDLE.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   req       [NREQ-1:0]         write request per requester
//   req_data  [NREQ*DATAWIDTH]   requester i data at [i*DATAWIDTH +: DATAWIDTH]
//   lock      [NREQ-1:0]         hold-ownership request (CREG_ARB_LOCK_EN only)
//   ack       [NREQ-1:0]         one-hot write acknowledge pulse
//   reg_data  [DATAWIDTH-1:0]    current register value
//   reg_valid                    register written at least once since reset
//   reg_update                   pulse: reg_data was loaded this cycle
//   owner     [clog2(NREQ)-1:0]  most recent writer
//   write_count [CNTWIDTH-1:0]   saturating count of completed writes
// ----------------------------------------------------------------------------
module cregister_arbiter
  import cregister_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int CNTWIDTH  = DEF_CNTWIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] req_data,
`ifdef CREG_ARB_LOCK_EN
  input  logic [NREQ-1:0]           lock,
`endif
  output logic [NREQ-1:0]           ack,
  output logic [DATAWIDTH-1:0]      reg_data,
  output logic                      reg_valid,
  output logic                      reg_update,
  output logic [clog2(NREQ)-1:0]    owner,
  output logic [CNTWIDTH-1:0]       write_count
);

  localparam int IDXW = clog2(NREQ);

  logic [NREQ-1:0]      r_ack;
  logic [DATAWIDTH-1:0] r_data;
  logic                 r_valid;
  logic                 r_update;
  logic [IDXW-1:0]      r_owner;
  logic [CNTWIDTH-1:0]  r_count;
  logic [IDXW-1:0]      r_ptr;
  arb_state_e           r_state;

  logic [NREQ-1:0]      w_elig;
  logic [NREQ-1:0]      w_grant;
  logic [IDXW-1:0]      w_idx;
  logic                 w_vld;
  logic [DATAWIDTH-1:0] w_wdata;
  logic [IDXW-1:0]      w_next_ptr;

  // A requester acknowledged this cycle is still showing its old request, so
  // it is masked; while LOCKED only the owner can compete.
  always_comb begin
    w_elig = req & ~r_ack;
    if (r_state == ST_LOCKED) w_elig = w_elig & (NREQ'(1) << r_owner);
  end

  rr_arbiter_core #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_core (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_vld)
  );

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == IDXW'(i)) w_wdata = req_data[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  assign w_next_ptr = (w_idx == IDXW'(NREQ - 1)) ? '0 : w_idx + IDXW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_update <= 1'b0;
      r_owner  <= '0;
      r_count  <= '0;
      r_ptr    <= '0;
      r_state  <= ST_IDLE;
    end else begin
      r_ack    <= w_grant;
      r_update <= w_vld;
      if (w_vld) begin
        r_data  <= w_wdata;
        r_owner <= w_idx;
        r_valid <= 1'b1;
        if (r_count != '1) r_count <= r_count + CNTWIDTH'(1);
        // The pointer is frozen while a lock holds ownership.
        if (r_state == ST_IDLE) r_ptr <= w_next_ptr;
      end
`ifdef CREG_ARB_LOCK_EN
      case (r_state)
        ST_IDLE: begin
          if (w_vld && lock[w_idx]) r_state <= ST_LOCKED;
        end
        ST_LOCKED: begin
          // Releasing the lock does not cancel a write granted this cycle.
          if (!lock[r_owner]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
`endif
    end
  end

  assign ack         = r_ack;
  assign reg_data    = r_data;
  assign reg_valid   = r_valid;
  assign reg_update  = r_update;
  assign owner       = r_owner;
  assign write_count = r_count;

endmodule

// File: tb/tb_cregister_arbiter.sv
module tb_cregister_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    req;
  logic [31:0]   req_data;
`ifdef CREG_ARB_LOCK_EN
  logic [3:0]    lock;
`endif
  logic [3:0]    ack;
  logic [7:0]    reg_data;
  logic          reg_valid;
  logic          reg_update;
  logic [1:0]    owner;
  logic [3:0]    write_count;

  cregister_arbiter #(
    .NREQ      (NREQ),
    .DATAWIDTH (DW),
    .CNTWIDTH  (CW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_data    (req_data),
`ifdef CREG_ARB_LOCK_EN
    .lock        (lock),
`endif
    .ack         (ack),
    .reg_data    (reg_data),
    .reg_valid   (reg_valid),
    .reg_update  (reg_update),
    .owner       (owner),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected outputs, tagged with the cycle in which they must be visible.
  typedef struct {
    int         cyc;
    logic [3:0] ack;
    logic [7:0] data;
    logic       valid;
    logic       upd;
    logic [1:0] owner;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];

  // Reference model state, plain integers.
  int         m_ptr, m_owner, m_count;
  logic [7:0] m_data;
  bit         m_valid, m_locked;
  logic [3:0] m_ack;

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_count = 0; m_data = 0;
    m_valid = 0; m_locked = 0; m_ack = 0;
  endtask

  // Predict the outputs after the next rising edge from the current inputs.
  task automatic model_step();
    logic [3:0] elig;
    int         g;
    bit         lk_n;
    logic       upd;
    exp_t       e;
    upd = 1'b0;
    if (!reset_n) begin
      model_reset();
    end else begin
      elig = req & ~m_ack;
      if (m_locked) elig = elig & (4'b0001 << m_owner);
      g = -1;
      for (int i = 0; i < NREQ; i++) begin
        int j;
        j = (m_ptr + i) % NREQ;
        if (g < 0 && elig[j]) g = j;
      end
      lk_n = m_locked;
`ifdef CREG_ARB_LOCK_EN
      if (m_locked) lk_n = lock[m_owner];
      else          lk_n = (g >= 0) && lock[g];
`endif
      if (g >= 0) begin
        m_data = req_data[g*8 +: 8];
        if (!m_locked) m_ptr = (g + 1) % NREQ;
        m_owner = g;
        m_valid = 1;
        if (m_count < 15) m_count++;
        m_ack = 4'b0001 << g;
        upd = 1'b1;
      end else begin
        m_ack = 4'b0000;
      end
      m_locked = lk_n;
    end
    e.cyc = cyc + 1; e.ack = m_ack; e.data = m_data; e.valid = m_valid;
    e.upd = upd; e.owner = 2'(m_owner); e.cnt = 4'(m_count);
    q.push_back(e);
  endtask

  // Monitor: compares DUT outputs against the scoreboard mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      if (q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("stale_expectation", 32'(e.cyc), 32'(cyc));
      end else if (q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("ack", 32'(ack), 32'(e.ack));
        chk("reg_data", 32'(reg_data), 32'(e.data));
        chk("reg_valid", 32'(reg_valid), 32'(e.valid));
        chk("reg_update", 32'(reg_update), 32'(e.upd));
        chk("owner", 32'(owner), 32'(e.owner));
        chk("write_count", 32'(write_count), 32'(e.cnt));
      end
    end
  end

  task automatic tick(input logic rstn, input logic [3:0] r, input logic [31:0] d);
    @(posedge clk);
    #1;
    reset_n  = rstn;
    req      = r;
    req_data = d;
    model_step();
  endtask

  logic [3:0] rr_ack [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [7:0] rr_dat [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  bit         pend [4];
  logic [7:0] adat [4];

  initial begin
    reset_n = 1'b0; req = '0; req_data = '0;
`ifdef CREG_ARB_LOCK_EN
    lock = '0;
`endif
    model_reset();
    for (int i = 0; i < 4; i++) begin pend[i] = 0; adat[i] = 0; end

    // Reset, then idle for 10 cycles.
    tick(1'b0, 4'h0, 32'h0);
    tick(1'b0, 4'h0, 32'h0);
    for (int n = 0; n < 10; n++) tick(1'b1, 4'h0, 32'h0);
    chk("idle_valid", 32'(reg_valid), 32'h0);
    chk("idle_count", 32'(write_count), 32'h0);

    // All four requesting with fixed data: strict rotation 0,1,2,3,0.
    for (int n = 0; n < 6; n++) begin
      tick(1'b1, 4'hF, 32'h4433_2211);
      if (n >= 1) begin
        chk("rr_order_ack", 32'(ack), 32'(rr_ack[n-1]));
        chk("rr_order_data", 32'(reg_data), 32'(rr_dat[n-1]));
      end
    end

    // Lone requester 2: writes every other cycle.
    for (int n = 0; n < 8; n++) tick(1'b1, 4'h4, 32'h00A5_0000);
    tick(1'b1, 4'h0, 32'h0);
    chk("lone_owner", 32'(owner), 32'h2);
    chk("lone_data", 32'(reg_data), 32'hA5);

    // Enough writes to saturate the 4-bit counter.
    for (int n = 0; n < 20; n++) tick(1'b1, 4'h3, {16'h0, 8'($urandom), 8'($urandom)});
    tick(1'b1, 4'h0, 32'h0);
    chk("count_saturated", 32'(write_count), 32'hF);

    // Reset lands while requester 1 is being granted.
    tick(1'b1, 4'h2, 32'h0000_BB00);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_data", 32'(reg_data), 32'h0);
    tick(1'b0, 4'h2, 32'h0000_BB00);
    tick(1'b0, 4'h2, 32'h0000_BB00);
    chk("rst_hold_ack", 32'(ack), 32'h0);
    tick(1'b1, 4'h6, 32'h00CC_BB00);
    tick(1'b1, 4'h4, 32'h00CC_BB00);
    chk("post_rst_first", 32'(ack), 32'h2);
    tick(1'b1, 4'h0, 32'h0);

`ifdef CREG_ARB_LOCK_EN
    // Requester 3 takes and keeps ownership, then releases.
    lock = 4'h8;
    for (int n = 0; n < 8; n++) tick(1'b1, 4'h9, 32'h7700_0066);
    lock = 4'h0;
    tick(1'b1, 4'h9, 32'h7700_0066);
    tick(1'b1, 4'h9, 32'h7700_0066);
    tick(1'b1, 4'h0, 32'h0);
`endif

    // Randomized traffic obeying the hold-until-ack protocol.
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (pend[i] && m_ack[i]) pend[i] = 0;
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1;
          adat[i] = 8'($urandom);
        end
        req[i] = pend[i];
        req_data[i*8 +: 8] = adat[i];
`ifdef CREG_ARB_LOCK_EN
        lock[i] = ($urandom_range(0, 2) == 0);
`endif
      end
      model_step();
    end

`ifdef CREG_ARB_LOCK_EN
    lock = '0;
`endif
    for (int n = 0; n < 4; n++) tick(1'b1, 4'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cregister_arbiter.md
# cregister_arbiter

Shared-write front end for a single Impulse C data register. Up to NREQ hardware processes request writes; a round-robin arbiter selects at most one writer per cycle, loads its data into an internal register and acknowledges it. The block sits between concurrent producer processes and any consumer that reads the shared value, replacing direct multi-driver access to the register's enable/data pins.

## Interface
- NREQ, 4, number of requesters (2..16)
- DATAWIDTH, 8, register width in bits
- CNTWIDTH, 16, width of the write counter
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NREQ  write request per requester
- req_data  in  NREQ*DATAWIDTH  requester i data at bits [i*DATAWIDTH +: DATAWIDTH]
- lock  in  NREQ  hold-ownership request (present only with CREG_ARB_LOCK_EN)
- ack  out  NREQ  one-hot write acknowledge, one-cycle pulse
- reg_data  out  DATAWIDTH  current register value
- reg_valid  out  1  register has been written at least once since reset
- reg_update  out  1  one-cycle pulse: reg_data changed this cycle
- owner  out  clog2(NREQ)  index of most recent writer
- write_count  out  CNTWIDTH  saturating count of completed writes

## Operation
- Eligible set: req[i] & ~ack[i] (a requester acked this cycle is masked; lone requester writes at most every other cycle).
- Round-robin pointer ptr: search starts at ptr, wraps from NREQ-1 to 0; first eligible index is grant g. After a write, ptr <= (g+1) mod NREQ; otherwise unchanged.
- On write: reg_data <= req_data slice g, owner <= g, ack <= onehot(g), reg_update <= 1, reg_valid <= 1, write_count <= write_count+1 unless all-ones (saturates, never wraps).
- No eligible request: ack = 0, reg_update = 0, all state held.
- Requesters hold req and data stable until ack; drop req or present next data in the cycle after ack.
- FSM (2-bit state): IDLE (arbitrating all), LOCKED (only owner eligible). Without the macro the FSM stays in IDLE.
- Reset values: reg_data 0, reg_valid 0, ack 0, reg_update 0, owner 0, write_count 0, ptr 0, state IDLE.
- Reset asserted mid-operation: immediate clear of all outputs/state; an in-flight grant is discarded with no ack; first grant after release starts search at index 0.

## Timing
- Grant combinational in cycle k from req, ack and ptr; write commits on rising edge ending cycle k.
- Cycle k+1: ack[g], reg_update, new reg_data, owner, write_count all visible together (latency 1).
- Sustained throughput: one write per cycle when at least two requesters are active.
- No combinational path from req/req_data to any output.

## Configuration
- CREG_ARB_LOCK_EN defined: lock port present. A grant to g with lock[g]=1 moves IDLE->LOCKED; in LOCKED only owner is eligible (ack mask still applies); when lock[owner]=0 at an edge, state returns to IDLE, and any write granted in that cycle still completes. ptr is not advanced while LOCKED.
- Undefined: no lock port, no LOCKED state, pure round-robin.

## Structure
- Package cregister_arb_pkg: state encoding (ST_IDLE, ST_LOCKED), clog2 function, default NREQ/DATAWIDTH/CNTWIDTH constants.
- Sub-module rr_arbiter_core: combinational rotate-priority-rotate back, inputs eligible mask and ptr, outputs one-hot grant, index and valid. Top level holds FSM, data register, counters.

## Test plan
- After reset, req=4'b0000 -> reg_data=0, reg_valid=0, ack=0, write_count=0 for 10 cycles.
- req=4'b1111, data 0x11/0x22/0x33/0x44 held -> acks in order 0,1,2,3,0, reg_data 0x11,0x22,0x33,0x44, one write per cycle.
- Only req[2] high continuously, data 0xA5 -> ack[2] every other cycle, reg_update aligned with ack, owner=2.
- Preload write_count to all-ones via 2^CNTWIDTH writes (CNTWIDTH=4) -> count stays 15 on further writes.
- reset_n low in the cycle req[1] is granted -> no ack, reg_data=0; after release req=4'b0110 grants index 1 first.
- With CREG_ARB_LOCK_EN: lock[3]=1, req=4'b1001 -> only index 3 acked until lock[3] drops; next grant goes to index 0.
